// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encodings used by the router control blocks.
package router_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_DECODE_ADDRESS     = 4'd0;
    localparam state_t S_LOAD_FIRST_DATA    = 4'd1;
    localparam state_t S_LOAD_DATA          = 4'd2;
    localparam state_t S_FIFO_FULL_STATE    = 4'd3;
    localparam state_t S_LOAD_AFTER_FULL    = 4'd4;
    localparam state_t S_LOAD_PARITY        = 4'd5;
    localparam state_t S_CHECK_PARITY_ERROR = 4'd6;
    localparam state_t S_WAIT_TILL_EMPTY    = 4'd7;
    localparam state_t S_DROP_PACKET        = 4'd8;

endpackage

// File: rtl/router_wait_timer.sv
// Saturating cycle counter for the WAIT_TILL_EMPTY timeout; tc flags the last allowed cycle.
module router_wait_timer #(
    parameter int unsigned WAIT_MAX = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(WAIT_MAX))) begin
            count <= count + CNT_W'(1);
        end
    end

    // With WAIT_MAX == 0 the timeout is disabled and tc never asserts
    assign tc = (WAIT_MAX > 0) && (count == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/router_fsm_mc.sv
// Multi-channel router control FSM: decodes header address, sequences payload/parity
// writes, waits for or drops packets, with Moore state decodes.
module router_fsm_mc
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned WAIT_MAX = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              drop_state,
    output logic              timeout_err,
    output logic [NUM_CH-1:0] ch_sel
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr;
    logic              in_range;
    logic              empty_in;
    logic              empty_addr;
    logic              sr_addr;
    logic              sr_hit;
    logic              wait_clear;
    logic              wait_en;
    logic              wait_tc;

    // Channel lookups via compare loops so out-of-range header addresses never index the vectors
    always_comb begin
        empty_in   = 1'b0;
        empty_addr = 1'b0;
        sr_addr    = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (data_in == ADDR_W'(i)) empty_in = fifo_empty[i];
            if (addr == ADDR_W'(i)) begin
                empty_addr = fifo_empty[i];
                sr_addr    = soft_reset[i];
            end
        end
    end

    assign in_range = (32'(data_in) < NUM_CH);
    assign sr_hit   = (state != S_DECODE_ADDRESS) && sr_addr;

    always_comb begin
        next_state = state;
        case (state)
            S_DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!in_range)     next_state = S_DROP_PACKET;
                    else if (empty_in) next_state = S_LOAD_FIRST_DATA;
                    else               next_state = S_WAIT_TILL_EMPTY;
                end
            end
            S_LOAD_FIRST_DATA: next_state = S_LOAD_DATA;
            S_LOAD_DATA: begin
                if (fifo_full)       next_state = S_FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = S_LOAD_PARITY;
            end
            S_FIFO_FULL_STATE: begin
                if (!fifo_full) next_state = S_LOAD_AFTER_FULL;
            end
            S_LOAD_AFTER_FULL: begin
                if (parity_done)        next_state = S_DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = S_LOAD_PARITY;
                else                    next_state = S_LOAD_DATA;
            end
            S_LOAD_PARITY: next_state = S_CHECK_PARITY_ERROR;
            S_CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? S_FIFO_FULL_STATE : S_DECODE_ADDRESS;
            end
            S_WAIT_TILL_EMPTY: begin
                if (empty_addr)   next_state = S_LOAD_FIRST_DATA;
                else if (wait_tc) next_state = S_DROP_PACKET;
            end
            S_DROP_PACKET: begin
                if (!pkt_valid) next_state = S_DECODE_ADDRESS;
            end
            default: next_state = S_DECODE_ADDRESS;
        endcase
        if (sr_hit) next_state = S_DECODE_ADDRESS;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_DECODE_ADDRESS;
            addr  <= '0;
        end else begin
            state <= next_state;
            if (sr_hit) begin
                addr <= '0;
            end else if ((state == S_DECODE_ADDRESS) && pkt_valid && in_range) begin
                addr <= data_in;
            end
        end
    end

    assign wait_clear = (state != S_WAIT_TILL_EMPTY) && (next_state == S_WAIT_TILL_EMPTY);
    assign wait_en    = (state == S_WAIT_TILL_EMPTY);

    router_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (wait_clear),
        .enable (wait_en),
        .tc     (wait_tc)
    );

    // Pulse only when the timeout actually causes the drop (a soft reset wins)
    assign timeout_err = (state == S_WAIT_TILL_EMPTY) && !empty_addr && wait_tc && !sr_addr;

    assign detect_add    = (state == S_DECODE_ADDRESS);
    assign lfd_state     = (state == S_LOAD_FIRST_DATA);
    assign ld_state      = (state == S_LOAD_DATA);
    assign full_state    = (state == S_FIFO_FULL_STATE);
    assign laf_state     = (state == S_LOAD_AFTER_FULL);
    assign rst_int_reg   = (state == S_CHECK_PARITY_ERROR);
    assign drop_state    = (state == S_DROP_PACKET);
    assign write_enb_reg = (state == S_LOAD_DATA) || (state == S_LOAD_AFTER_FULL) ||
                           (state == S_LOAD_PARITY);
    assign busy          = !((state == S_DECODE_ADDRESS) || (state == S_LOAD_DATA) ||
                             (state == S_DROP_PACKET));

    always_comb begin
        ch_sel = '0;
        if ((state != S_DECODE_ADDRESS) && (state != S_DROP_PACKET)) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ch_sel[i] = (addr == ADDR_W'(i));
            end
        end
    end

endmodule

// File: tb/tb_router_fsm_mc.sv
// Self-checking bench for router_fsm_mc: directed packet scenarios plus randomized
// traffic compared against a packet-phase reference model.
module tb_router_fsm_mc;

    localparam int NUM_CH   = 3;
    localparam int ADDR_W   = 2;
    localparam int WAIT_MAX = 8;

    // Output bundle order: {detect_add, lfd, ld, full, laf, rst_int, write_enb, busy, drop}
    localparam logic [8:0] B_DECODE = 9'b100000000;
    localparam logic [8:0] B_LFD    = 9'b010000010;
    localparam logic [8:0] B_LD     = 9'b001000100;
    localparam logic [8:0] B_FULL   = 9'b000100010;
    localparam logic [8:0] B_LAF    = 9'b000010110;
    localparam logic [8:0] B_LP     = 9'b000000110;
    localparam logic [8:0] B_CPE    = 9'b000001010;
    localparam logic [8:0] B_WAIT   = 9'b000000010;
    localparam logic [8:0] B_DROP   = 9'b000000001;

    typedef enum {P_IDLE, P_FIRST, P_BODY, P_STALL, P_RESUME, P_PARITY, P_CHECK,
                  P_WAIT, P_DROP} phase_t;

    logic              clock;
    logic              reset;
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              detect_add, lfd_state, ld_state, full_state, laf_state;
    logic              rst_int_reg, write_enb_reg, busy, drop_state, timeout_err;
    logic [NUM_CH-1:0] ch_sel;

    int     n_checks = 0;
    int     n_errors = 0;
    phase_t m_state;
    int     m_addr;
    int     m_wait;

    router_fsm_mc #(
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .full_state    (full_state),
        .laf_state     (laf_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy),
        .drop_state    (drop_state),
        .timeout_err   (timeout_err),
        .ch_sel        (ch_sel)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] phase_bundle(input phase_t p);
        case (p)
            P_IDLE:   return B_DECODE;
            P_FIRST:  return B_LFD;
            P_BODY:   return B_LD;
            P_STALL:  return B_FULL;
            P_RESUME: return B_LAF;
            P_PARITY: return B_LP;
            P_CHECK:  return B_CPE;
            P_WAIT:   return B_WAIT;
            default:  return B_DROP;
        endcase
    endfunction

    function automatic logic [8:0] dut_bundle();
        return {detect_add, lfd_state, ld_state, full_state, laf_state,
                rst_int_reg, write_enb_reg, busy, drop_state};
    endfunction

    task automatic model_reset();
        m_state = P_IDLE;
        m_addr  = 0;
        m_wait  = 0;
    endtask

    // Advance the packet-phase model by one clock using the inputs seen at the edge
    task automatic model_step();
        phase_t nxt;
        bit     sr;
        if (reset) begin
            model_reset();
            return;
        end
        sr  = (m_state != P_IDLE) && soft_reset[m_addr];
        nxt = m_state;
        case (m_state)
            P_IDLE: if (pkt_valid) begin
                if (int'(data_in) >= NUM_CH) nxt = P_DROP;
                else begin
                    m_addr = int'(data_in);
                    m_wait = 0;
                    nxt = fifo_empty[m_addr] ? P_FIRST : P_WAIT;
                end
            end
            P_FIRST:  nxt = P_BODY;
            P_BODY:   nxt = fifo_full ? P_STALL : (pkt_valid ? P_BODY : P_PARITY);
            P_STALL:  nxt = fifo_full ? P_STALL : P_RESUME;
            P_RESUME: nxt = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_BODY);
            P_PARITY: nxt = P_CHECK;
            P_CHECK:  nxt = fifo_full ? P_STALL : P_IDLE;
            P_WAIT: begin
                if (fifo_empty[m_addr])        nxt = P_FIRST;
                else if (m_wait == WAIT_MAX-1) nxt = P_DROP;
                else                           m_wait++;
            end
            default: if (!pkt_valid) nxt = P_IDLE;
        endcase
        if (sr) begin
            nxt    = P_IDLE;
            m_addr = 0;
        end
        m_state = nxt;
    endtask

    task automatic cmp_model(input string tag);
        logic [NUM_CH-1:0] exp_sel;
        logic              exp_to;
        exp_sel = '0;
        if (m_state != P_IDLE && m_state != P_DROP) exp_sel[m_addr] = 1'b1;
        exp_to = (m_state == P_WAIT) && !fifo_empty[m_addr] && (m_wait == WAIT_MAX-1) &&
                 !soft_reset[m_addr];
        check_val({tag, "_state"}, 32'(dut_bundle()), 32'(phase_bundle(m_state)));
        check_val({tag, "_chsel"}, 32'(ch_sel), 32'(exp_sel));
        check_val({tag, "_tmo"}, 32'(timeout_err), 32'(exp_to));
    endtask

    // One clock: model follows the edge, then new inputs are applied and outputs compared
    task automatic step(input string tag, input logic pv, input logic [ADDR_W-1:0] din,
                        input logic full, input logic [NUM_CH-1:0] empty,
                        input logic [NUM_CH-1:0] sr, input logic pd, input logic lpv);
        @(posedge clock);
        model_step();
        #1;
        pkt_valid     = pv;
        data_in       = din;
        fifo_full     = full;
        fifo_empty    = empty;
        soft_reset    = sr;
        parity_done   = pd;
        low_pkt_valid = lpv;
        #3;
        cmp_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0; fifo_empty = '1;
        soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
        model_reset();
        #3;
        check_val("rst_state", 32'(dut_bundle()), 32'(B_DECODE));
        check_val("rst_chsel", 32'(ch_sel), 32'd0);
        check_val("rst_tmo", 32'(timeout_err), 32'd0);
        do_reset();

        // Normal packet to channel 1 with four payload bytes
        step("p1_dec", 1, 2'd1, 0, 3'b111, 0, 0, 0);
        check_val("p1_dec", 32'(dut_bundle()), 32'(B_DECODE));
        step("p1_lfd", 1, 2'd3, 0, 3'b111, 0, 0, 0);
        check_val("p1_lfd", 32'(dut_bundle()), 32'(B_LFD));
        check_val("p1_sel", 32'(ch_sel), 32'b010);
        step("p1_ld1", 1, 2'd2, 0, 3'b111, 0, 0, 0);
        check_val("p1_ld1", 32'(dut_bundle()), 32'(B_LD));
        step("p1_ld2", 1, 2'd0, 0, 3'b111, 0, 0, 0);
        step("p1_ld3", 0, 2'd1, 0, 3'b111, 0, 0, 0);
        check_val("p1_ld3", 32'(dut_bundle()), 32'(B_LD));
        step("p1_lp", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        check_val("p1_lp", 32'(dut_bundle()), 32'(B_LP));
        step("p1_cpe", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        check_val("p1_cpe", 32'(dut_bundle()), 32'(B_CPE));
        step("p1_end", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        check_val("p1_end", 32'(dut_bundle()), 32'(B_DECODE));

        // Out-of-range header address is dropped without writes
        step("p2_dec", 1, 2'd3, 0, 3'b111, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step("p2_drop", (k < 2), 2'd1, 0, 3'b111, 0, 0, 0);
            check_val("p2_drop", 32'(dut_bundle()), 32'(B_DROP));
            check_val("p2_sel", 32'(ch_sel), 32'd0);
        end
        step("p2_end", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        check_val("p2_end", 32'(dut_bundle()), 32'(B_DECODE));

        // Wait on busy channel 2 until timeout, then drop
        step("p3_dec", 1, 2'd2, 0, 3'b011, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step("p3_wait", 1, 2'd0, 0, 3'b011, 0, 0, 0);
            check_val("p3_wait", 32'(dut_bundle()), 32'(B_WAIT));
            check_val("p3_tmo", 32'(timeout_err), 32'(k == 8));
        end
        step("p3_drop", 0, 2'd0, 0, 3'b011, 0, 0, 0);
        check_val("p3_drop", 32'(dut_bundle()), 32'(B_DROP));
        step("p3_end", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        check_val("p3_end", 32'(dut_bundle()), 32'(B_DECODE));

        // Channel 2 drains on the last allowed wait cycle: load wins over timeout
        step("p4_dec", 1, 2'd2, 0, 3'b011, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step("p4_wait", 1, 2'd0, 0, (k == 8) ? 3'b111 : 3'b011, 0, 0, 0);
            check_val("p4_tmo", 32'(timeout_err), 32'd0);
        end
        step("p4_lfd", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        check_val("p4_lfd", 32'(dut_bundle()), 32'(B_LFD));
        check_val("p4_sel", 32'(ch_sel), 32'b100);
        step("p4_ld", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        step("p4_lp", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        step("p4_cpe", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        step("p4_end", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        check_val("p4_end", 32'(dut_bundle()), 32'(B_DECODE));

        // FIFO full for five cycles, resume with low_pkt_valid
        step("p5_dec", 1, 2'd0, 0, 3'b111, 0, 0, 0);
        step("p5_lfd", 1, 2'd0, 0, 3'b111, 0, 0, 0);
        step("p5_ld", 1, 2'd0, 1, 3'b111, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step("p5_full", 1, 2'd0, (k < 5), 3'b111, 0, 0, 0);
            check_val("p5_full", 32'(dut_bundle()), 32'(B_FULL));
        end
        step("p5_laf", 0, 2'd0, 0, 3'b111, 0, 0, 1);
        check_val("p5_laf", 32'(dut_bundle()), 32'(B_LAF));
        step("p5_lp", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        check_val("p5_lp", 32'(dut_bundle()), 32'(B_LP));
        step("p5_cpe", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        step("p5_end", 0, 2'd0, 0, 3'b111, 0, 0, 0);

        // Soft reset: other channel ignored, own channel aborts
        step("p6_dec", 1, 2'd0, 0, 3'b111, 0, 0, 0);
        step("p6_lfd", 1, 2'd0, 0, 3'b111, 0, 0, 0);
        step("p6_ld", 1, 2'd0, 0, 3'b111, 3'b010, 0, 0);
        step("p6_ign", 1, 2'd0, 0, 3'b111, 3'b001, 0, 0);
        check_val("p6_ign", 32'(dut_bundle()), 32'(B_LD));
        step("p6_sr", 0, 2'd0, 0, 3'b111, 0, 0, 0);
        check_val("p6_sr", 32'(dut_bundle()), 32'(B_DECODE));
        check_val("p6_sel", 32'(ch_sel), 32'd0);

        // Asynchronous reset in FIFO_FULL_STATE
        step("p7_dec", 1, 2'd1, 0, 3'b111, 0, 0, 0);
        step("p7_lfd", 1, 2'd1, 0, 3'b111, 0, 0, 0);
        step("p7_ld", 1, 2'd1, 1, 3'b111, 0, 0, 0);
        step("p7_full", 1, 2'd1, 1, 3'b111, 0, 0, 0);
        check_val("p7_full", 32'(dut_bundle()), 32'(B_FULL));
        #1 reset = 1'b1;
        #1;
        check_val("p7_arst", 32'(dut_bundle()), 32'(B_DECODE));
        check_val("p7_asel", 32'(ch_sel), 32'd0);
        model_reset();
        pkt_valid = 1'b0; fifo_full = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        #3;
        check_val("p7_nowr", 32'(write_enb_reg), 32'd0);
        cmp_model("p7_post");

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic [NUM_CH-1:0] sr;
            logic [NUM_CH-1:0] em;
            sr = ($urandom_range(0, 29) == 0) ? NUM_CH'($urandom_range(1, 7)) : '0;
            for (int b = 0; b < NUM_CH; b++) em[b] = ($urandom_range(0, 9) < 7);
            step("rnd", ($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), em, sr,
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/router_fsm_mc.md
ROUTER_FSM_MC -- requirements
Module: router_fsm_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of output channels, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 2, header address width, SHALL satisfy 2**ADDR_W >= NUM_CH.
REQ-003 SHALL have parameter WAIT_MAX, default 0, WAIT_TILL_EMPTY timeout in cycles; 0 disables the timeout.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pkt_valid  in  1  packet byte valid from source.
REQ-007 data_in  in  ADDR_W  header address bits of the current byte.
REQ-008 fifo_full  in  1  full flag of the selected channel FIFO.
REQ-009 fifo_empty  in  NUM_CH  per-channel FIFO empty flags.
REQ-010 soft_reset  in  NUM_CH  per-channel read-timeout soft resets.
REQ-011 parity_done, low_pkt_valid  in  1 each  status from the register block.
REQ-012 detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg, write_enb_reg, busy  out  1 each  state decodes.
REQ-013 drop_state  out  1  packet being discarded.
REQ-014 timeout_err  out  1  one-cycle pulse on WAIT_TILL_EMPTY timeout.
REQ-015 ch_sel  out  NUM_CH  one-hot of latched destination, all-zero when none.

Function
REQ-016 States SHALL be DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY, DROP_PACKET, 4-bit encoding.
REQ-017 DECODE_ADDRESS: pkt_valid with data_in >= NUM_CH -> DROP_PACKET; with fifo_empty[data_in] -> LOAD_FIRST_DATA; with !fifo_empty[data_in] -> WAIT_TILL_EMPTY; else stay.
REQ-018 Address SHALL be latched into addr register whenever in DECODE_ADDRESS and pkt_valid is high and data_in < NUM_CH.
REQ-019 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-020 LOAD_DATA: fifo_full -> FIFO_FULL_STATE (priority); else !pkt_valid -> LOAD_PARITY; else stay.
REQ-021 LOAD_PARITY -> CHECK_PARITY_ERROR; CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE else DECODE_ADDRESS.
REQ-022 FIFO_FULL_STATE: stay while fifo_full, else LOAD_AFTER_FULL.
REQ-023 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-024 WAIT_TILL_EMPTY: fifo_empty[addr] -> LOAD_FIRST_DATA (priority over timeout); else if WAIT_MAX>0 and wait counter == WAIT_MAX-1 -> DROP_PACKET with timeout_err high that cycle; else stay.
REQ-025 Wait counter SHALL clear on WAIT_TILL_EMPTY entry, increment each cycle within it, width clog2(WAIT_MAX+1), never wrap.
REQ-026 DROP_PACKET: stay while pkt_valid; on pkt_valid low (parity byte) -> DECODE_ADDRESS; no write occurs.
REQ-027 soft_reset[addr] high in any state except DECODE_ADDRESS SHALL force DECODE_ADDRESS next cycle and clear addr; soft_reset of other channels SHALL be ignored.
REQ-028 Outputs SHALL be Moore decodes: detect_add=DECODE_ADDRESS; write_enb_reg=LOAD_DATA|LOAD_AFTER_FULL|LOAD_PARITY; busy=all states except DECODE_ADDRESS, LOAD_DATA, DROP_PACKET; rst_int_reg=CHECK_PARITY_ERROR; drop_state=DROP_PACKET.
REQ-029 ch_sel SHALL be one-hot of addr in all states except DECODE_ADDRESS and DROP_PACKET, where it is zero.

Reset
REQ-030 reset SHALL asynchronously force DECODE_ADDRESS, addr=0, wait counter=0; outputs detect_add=1, all others 0, ch_sel=0.
REQ-031 reset asserted mid-packet SHALL abandon the packet with no further write_enb_reg.

Structure
REQ-032 State encoding constants SHALL live in shared package router_pkg, reused by router_top.
REQ-033 Wait counter SHALL be sub-module router_wait_timer (clear, enable, terminal-count output).

Verification
REQ-034 NUM_CH=3, header addr 1, fifo_empty=3'b111, 4 payload bytes -> DECODE, LFD, LD x3, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE; ch_sel=3'b010.
REQ-035 NUM_CH=3, header addr 3 -> DROP_PACKET, write_enb_reg=0, busy=0 throughout, DECODE after pkt_valid falls.
REQ-036 WAIT_MAX=8, fifo_empty[2]=0 held -> timeout_err pulse at 8th WAIT cycle, then DROP_PACKET; same with fifo_empty[2] rising at cycle 8 -> LOAD_FIRST_DATA, no pulse.
REQ-037 fifo_full asserted in LOAD_DATA for 5 cycles -> FIFO_FULL_STATE 5 cycles, then LOAD_AFTER_FULL with low_pkt_valid=1 -> LOAD_PARITY.
REQ-038 addr=0 in LOAD_DATA, soft_reset=3'b010 -> no effect; soft_reset=3'b001 -> DECODE next cycle, ch_sel=0; async reset mid-FIFO_FULL -> immediate DECODE.
